// File: rtl/fusion_frame_scheduler.sv
// fusion_frame_scheduler
// Collects one raw vector per sensor, launches a frame into the fixed-latency
// fusion pipeline, tracks it to the result cycle and queues per-frame metadata
// for the consumer. Credits (frames in flight + queued entries) bound the
// result buffer so a result write is never refused.
// Optional feature macro: FUSION_SCHED_TIMEOUT_EN (partial-frame timeout with
// zero substitution of the missing sensors).
module fusion_frame_scheduler #(
    parameter int PIPE_LATENCY   = 4,
    parameter int OUT_DEPTH      = 4,
    parameter int ID_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   s_valid,
    output logic [2:0]                   s_ready,
    output logic [2:0]                   s_capture,
    output logic                         core_launch,
    output logic [2:0]                   core_zero_mask,
    input  logic [3:0]                   core_error,
    output logic                         res_wr_en,
    output logic [$clog2(OUT_DEPTH)-1:0] res_wr_ptr,
    output logic [$clog2(OUT_DEPTH)-1:0] res_rd_ptr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_frame_id,
    output logic [2:0]                   out_missing,
    output logic [3:0]                   out_error,
    output logic                         credit_stall
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_LAUNCH  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_have;
    logic [2:0]          w_s_ready;
    logic [2:0]          w_cap;
    logic [2:0]          w_have_acc;
    logic [2:0]          w_zero_mask;
    logic                w_timeout_hit;
    logic                w_launch;
    logic                w_stall;
    logic                w_credit_ok;
    logic                w_res;
    logic                w_out_valid;
    logic                w_pop;
    logic [ID_WIDTH-1:0] r_frame_id;
    logic [CW-1:0]       r_credits;

    // pipeline tracking shift register: one slot per cycle of latency
    logic                r_sr_vld  [PIPE_LATENCY];
    logic [ID_WIDTH-1:0] r_sr_id   [PIPE_LATENCY];
    logic [2:0]          r_sr_mask [PIPE_LATENCY];

    // metadata FIFO; slot index doubles as the result buffer slot
    logic [ID_WIDTH-1:0] r_mem_id   [OUT_DEPTH];
    logic [2:0]          r_mem_mask [OUT_DEPTH];
    logic [3:0]          r_mem_err  [OUT_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;

    // sensors are only accepted while collecting, and never during reset
    assign w_s_ready   = (!rst && (r_state == ST_COLLECT)) ? ~r_have : 3'b000;
    assign w_cap       = s_valid & w_s_ready;
    assign w_have_acc  = r_have | w_cap;
    assign w_credit_ok = (r_credits < CW'(OUT_DEPTH));
    assign w_res       = !rst && r_sr_vld[PIPE_LATENCY-1];
    assign w_out_valid = !rst && (r_count != {(AW+1){1'b0}});
    assign w_pop       = w_out_valid && out_ready;

`ifdef FUSION_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;

    assign w_timeout_hit = (w_have_acc != 3'b000) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_zero_mask   = ~r_have;

    // partial-frame age: runs from the first accept until the frame launches
    always_ff @(posedge clk) begin
        if (rst || w_launch) begin
            r_tcnt <= {TW{1'b0}};
        end else if ((r_state == ST_COLLECT) && (w_have_acc != 3'b000)) begin
            r_tcnt <= r_tcnt + TW'(1);
        end else begin
            r_tcnt <= r_tcnt;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign w_zero_mask   = 3'b000;
`endif

    // next-state and launch/stall decode
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_stall      = 1'b0;
        if (rst) begin
            w_state_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if ((w_have_acc == 3'b111) || w_timeout_hit) begin
                        w_state_next = ST_LAUNCH;
                    end else begin
                        w_state_next = ST_COLLECT;
                    end
                end
                ST_LAUNCH: begin
                    if (w_credit_ok) begin
                        w_launch     = 1'b1;
                        w_state_next = ST_COLLECT;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = ST_LAUNCH;
                    end
                end
                default: begin
                    w_state_next = ST_COLLECT;
                end
            endcase
        end
    end

    // state, sensor bookkeeping, frame ID and credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_have     <= 3'b000;
            r_frame_id <= {ID_WIDTH{1'b0}};
            r_credits  <= {CW{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (w_launch) begin
                r_have     <= 3'b000;
                r_frame_id <= r_frame_id + ID_WIDTH'(1);
            end else begin
                r_have     <= w_have_acc;
                r_frame_id <= r_frame_id;
            end
            case ({w_launch, w_pop})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // carry launched frame tags alongside the fixed pipeline latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_sr_vld[i]  <= 1'b0;
                r_sr_id[i]   <= {ID_WIDTH{1'b0}};
                r_sr_mask[i] <= 3'b000;
            end
        end else begin
            r_sr_vld[0]  <= w_launch;
            r_sr_id[0]   <= r_frame_id;
            r_sr_mask[0] <= w_zero_mask;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_id[i]   <= r_sr_id[i-1];
                r_sr_mask[i] <= r_sr_mask[i-1];
            end
        end
    end

    // metadata FIFO pointers and occupancy; push and pop both honoured
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
        end else begin
            r_wptr <= w_res ? (r_wptr + AW'(1)) : r_wptr;
            r_rptr <= w_pop ? (r_rptr + AW'(1)) : r_rptr;
            case ({w_res, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // metadata storage, written in the result cycle together with core_error
    always_ff @(posedge clk) begin
        if (w_res) begin
            r_mem_id[r_wptr]   <= r_sr_id[PIPE_LATENCY-1];
            r_mem_mask[r_wptr] <= r_sr_mask[PIPE_LATENCY-1];
            r_mem_err[r_wptr]  <= core_error;
        end else begin
            r_mem_id[r_wptr]   <= r_mem_id[r_wptr];
            r_mem_mask[r_wptr] <= r_mem_mask[r_wptr];
            r_mem_err[r_wptr]  <= r_mem_err[r_wptr];
        end
    end

    assign s_ready        = w_s_ready;
    assign s_capture      = w_cap;
    assign core_launch    = w_launch;
    assign core_zero_mask = w_launch ? w_zero_mask : 3'b000;
    assign credit_stall   = w_stall;
    assign res_wr_en      = w_res;
    assign res_wr_ptr     = rst ? {AW{1'b0}} : r_wptr;
    assign res_rd_ptr     = rst ? {AW{1'b0}} : r_rptr;
    assign out_valid      = w_out_valid;
    assign out_frame_id   = w_out_valid ? r_mem_id[r_rptr]   : {ID_WIDTH{1'b0}};
    assign out_missing    = w_out_valid ? r_mem_mask[r_rptr] : 3'b000;
    assign out_error      = w_out_valid ? r_mem_err[r_rptr]  : 4'h0;

endmodule

// File: tb/tb_fusion_frame_scheduler.sv
// Bench for fusion_frame_scheduler: a frame-level reference model (sensor
// set, pending frame, credit count, in-flight list with due cycles) predicts
// the handshake/launch/result behaviour each cycle; expected metadata is
// queued at the result cycle and a separate monitor pops it on every
// consumer handshake.
module tb_fusion_frame_scheduler;
    localparam int PIPE_LATENCY   = 4;
    localparam int OUT_DEPTH      = 4;
    localparam int ID_WIDTH       = 8;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int AW             = $clog2(OUT_DEPTH);

    logic                clk;
    logic                rst;
    logic [2:0]          s_valid;
    logic [2:0]          s_ready;
    logic [2:0]          s_capture;
    logic                core_launch;
    logic [2:0]          core_zero_mask;
    logic [3:0]          core_error;
    logic                res_wr_en;
    logic [AW-1:0]       res_wr_ptr;
    logic [AW-1:0]       res_rd_ptr;
    logic                out_valid;
    logic                out_ready;
    logic [ID_WIDTH-1:0] out_frame_id;
    logic [2:0]          out_missing;
    logic [3:0]          out_error;
    logic                credit_stall;

    fusion_frame_scheduler #(
        .PIPE_LATENCY(PIPE_LATENCY), .OUT_DEPTH(OUT_DEPTH),
        .ID_WIDTH(ID_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_capture(s_capture), .core_launch(core_launch),
        .core_zero_mask(core_zero_mask), .core_error(core_error),
        .res_wr_en(res_wr_en), .res_wr_ptr(res_wr_ptr), .res_rd_ptr(res_rd_ptr),
        .out_valid(out_valid), .out_ready(out_ready), .out_frame_id(out_frame_id),
        .out_missing(out_missing), .out_error(out_error), .credit_stall(credit_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int id; int mask; int due; } flight_t;
    typedef struct { int id; int miss; int err; int slot; } meta_t;

    flight_t fl_q[$];
    meta_t   sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    int m_have, m_full, m_mask, m_first, m_cred, m_cnt, m_wptr, m_id;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_clear();
        m_have = 0; m_full = 0; m_mask = 0; m_first = 0;
        m_cred = 0; m_cnt = 0; m_wptr = 0; m_id = 0;
        fl_q.delete();
        sb_q.delete();
    endfunction

    // one clock cycle: drive, predict, compare, advance the model
    task automatic step(input logic [2:0] sv, input logic ordy, input logic [3:0] err);
        int e_rdy, e_cap, e_launch, e_stall, e_res, e_ov, e_pop;
        flight_t f;
        s_valid = sv; out_ready = ordy; core_error = err;
        #2;
        e_rdy    = m_full ? 0 : (~m_have & 7);
        e_cap    = int'(sv) & e_rdy;
        e_launch = (m_full != 0 && m_cred < OUT_DEPTH) ? 1 : 0;
        e_stall  = (m_full != 0 && e_launch == 0) ? 1 : 0;
        e_res    = (fl_q.size() > 0 && fl_q[0].due == cyc) ? 1 : 0;
        e_ov     = (m_cnt > 0) ? 1 : 0;
        e_pop    = (e_ov != 0 && ordy) ? 1 : 0;
        chk("s_ready", int'(s_ready), e_rdy);
        chk("s_capture", int'(s_capture), e_cap);
        chk("core_launch", int'(core_launch), e_launch);
        chk("core_zero_mask", int'(core_zero_mask), e_launch != 0 ? m_mask : 0);
        chk("credit_stall", int'(credit_stall), e_stall);
        chk("res_wr_en", int'(res_wr_en), e_res);
        if (e_res != 0) chk("res_wr_ptr", int'(res_wr_ptr), m_wptr);
        chk("out_valid", int'(out_valid), e_ov);
        if (e_res != 0) begin
            f = fl_q.pop_front();
            sb_q.push_back('{f.id, f.mask, int'(err), m_wptr});
            m_wptr = (m_wptr + 1) % OUT_DEPTH;
            m_cnt++;
        end
        if (e_pop != 0) begin
            m_cnt--;
            m_cred--;
        end
        if (e_launch != 0) begin
            fl_q.push_back('{m_id, m_mask, cyc + PIPE_LATENCY});
            m_id = (m_id + 1) % (1 << ID_WIDTH);
            m_cred++;
            m_full = 0; m_have = 0; m_mask = 0;
        end else if (m_full == 0) begin
            if (m_have == 0 && e_cap != 0) m_first = cyc;
            m_have = m_have | e_cap;
            if (m_have == 7) begin
                m_full = 1; m_mask = 0;
            end
`ifdef FUSION_SCHED_TIMEOUT_EN
            else if (m_have != 0 && (cyc - m_first) == TIMEOUT_CYCLES - 1) begin
                m_full = 1; m_mask = ~m_have & 7;
            end
`endif
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    // one reset cycle with all outputs required idle
    task automatic do_reset();
        rst = 1'b1; s_valid = 3'b111; out_ready = 1'b1; core_error = 4'h0;
        #2;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_s_capture", int'(s_capture), 0);
        chk("rst_core_launch", int'(core_launch), 0);
        chk("rst_res_wr_en", int'(res_wr_en), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_credit_stall", int'(credit_stall), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        cyc++;
    endtask

    // monitor: every consumer handshake must match the oldest expected entry
    initial begin
        meta_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                chk("sb_has_entry", (sb_q.size() > 0) ? 1 : 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("out_frame_id", int'(out_frame_id), e.id);
                    chk("out_missing", int'(out_missing), e.miss);
                    chk("out_error", int'(out_error), e.err);
                    chk("res_rd_ptr", int'(res_rd_ptr), e.slot);
                end
            end
        end
    end

    initial begin
        logic [3:0] err;
        rst = 1'b1; s_valid = 3'b000; out_ready = 1'b0; core_error = 4'h0;
        model_clear();
        @(posedge clk); #1;
        do_reset();

        // all sensors at cycle 0: launch 1, result 5, out_valid 6
        step(3'b111, 1'b1, 4'h0);
        for (int i = 0; i < 9; i++) step(3'b000, 1'b1, 4'h0);

        // staggered sensors: s0 @0, s2 @3, s1 @7 -> launch @8
        do_reset();
        for (int c = 0; c < 16; c++) begin
            step((c == 0) ? 3'b001 : (c == 3) ? 3'b100 : (c == 7) ? 3'b010 : 3'b000,
                 1'b1, 4'h0);
        end

        // no consumer: four launches then credit stall; single pop; drain with wrap
        do_reset();
        for (int c = 0; c < 30; c++) step(3'b111, 1'b0, 4'h0);
        step(3'b111, 1'b1, 4'h0);
        for (int c = 0; c < 12; c++) step(3'b111, 1'b0, 4'h0);
        for (int c = 0; c < 60; c++) step(3'b111, 1'b1, 4'h0);

        // fault code only in the result cycle of frame 2
        do_reset();
        for (int c = 0; c < 30; c++) begin
            err = (fl_q.size() > 0 && fl_q[0].due == cyc && fl_q[0].id == 2) ? 4'h3 : 4'h0;
            step(3'b111, 1'b1, err);
        end

        // partial frame: only s0/s1 (times out only with the timeout build)
        do_reset();
        for (int c = 0; c < 100; c++) step(3'b011, 1'b1, 4'h0);
        for (int c = 0; c < 20; c++) step(3'b100, 1'b1, 4'h0);

        // reset two cycles after a launch discards the in-flight frame
        do_reset();
        step(3'b111, 1'b1, 4'h0);
        step(3'b000, 1'b1, 4'h0);
        step(3'b000, 1'b1, 4'h0);
        do_reset();
        for (int c = 0; c < 12; c++) step(3'b111, 1'b1, 4'h0);

        // randomized traffic with random backpressure and fault codes
        for (int c = 0; c < 3000; c++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)));
        end

        // drain: all expected entries must have been consumed
        for (int c = 0; c < 40; c++) step(3'b000, 1'b1, 4'h0);
        chk("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fusion_frame_scheduler.md
# fusion_frame_scheduler

Frame-level controller in front of the three-sensor fusion pipeline. Collects one raw vector per sensor through per-sensor valid/ready handshakes and fires a single-cycle launch into the free-running fusion pipeline. Tracks each launched frame through the fixed pipeline latency, writes the result into an external result buffer, and presents per-frame metadata (frame ID, missing-sensor mask, fault code) to the consumer with credit-based backpressure so the result buffer never overflows.

## Interface
- PIPE_LATENCY, 4: cycles from core_launch to the result being valid on the fusion pipeline output (≥1)
- OUT_DEPTH, 4: result buffer / metadata FIFO depth; power of two, ≥2
- ID_WIDTH, 8: frame ID width
- TIMEOUT_CYCLES, 64: partial-frame timeout (only with FUSION_SCHED_TIMEOUT_EN)

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  3  sensor i has a raw vector available
- s_ready  out  3  scheduler accepts sensor i this cycle
- s_capture  out  3  = s_valid & s_ready; load enable for the external raw-vector register of sensor i
- core_launch  out  1  one-cycle pulse: captured vectors are valid at the pipeline input this cycle
- core_zero_mask  out  3  sensors to be zero-substituted at the pipeline input; valid while core_launch=1
- core_error  in  4  fault monitor code, sampled in the result cycle
- res_wr_en  out  1  write the pipeline output into result buffer slot res_wr_ptr
- res_wr_ptr  out  log2(OUT_DEPTH)  result buffer write slot
- res_rd_ptr  out  log2(OUT_DEPTH)  result buffer slot belonging to the head metadata entry
- out_valid  out  1  head metadata entry and result slot are valid
- out_ready  in  1  consumer accepts the head entry
- out_frame_id  out  ID_WIDTH  frame ID of the head entry
- out_missing  out  3  sensors absent from the head frame
- out_error  out  4  core_error captured for the head frame
- credit_stall  out  1  complete frame held because no credit is available

## Operation
- FSM states: COLLECT, LAUNCH. Reset → COLLECT.
- COLLECT: have[2:0] register; s_ready[i] = !have[i]. Accept sets have[i]. If have | s_capture == 3'b111 → LAUNCH next cycle.
- LAUNCH: s_ready = 0. Credit ok (credits < OUT_DEPTH) → core_launch=1, core_zero_mask = ~have (3'b000 for a complete frame), push {id, mask} into a PIPE_LATENCY-deep shift register, frame_id += 1 (wraps modulo 2^ID_WIDTH), have cleared, → COLLECT. No credit → stay, credit_stall=1.
- credits = frames in flight + entries in the metadata FIFO. +1 on launch, −1 on out handshake; both in the same cycle → unchanged.
- Shift register output valid → res_wr_en=1, res_wr_ptr = FIFO write pointer; FIFO push {id, mask, core_error}. A push is never refused; credits guarantee space.
- out_valid = FIFO non-empty. Head is popped on out_valid & out_ready. Push and pop in the same cycle are both honoured, including at full and at empty (empty+push: out_valid rises the next cycle, no bypass).
- Pointers wrap modulo OUT_DEPTH.

## Timing
- Reset values: s_ready=3'b000 during reset, 3'b111 in the first cycle after reset; every other output 0; frame_id=0, credits=0, FIFO empty, shift register cleared.
- Last sensor accepted at cycle t → core_launch at t+1 when credit is available.
- Launch at L → res_wr_en at L+PIPE_LATENCY → out_valid at L+PIPE_LATENCY+1.
- Peak throughput: one frame per 2 cycles.
- Reset mid-operation: frames in flight and buffered are discarded and no res_wr_en is issued for them.

## Configuration
- FUSION_SCHED_TIMEOUT_EN defined:
  - A counter starts when the first sensor of a frame is accepted and clears on launch.
  - At TIMEOUT_CYCLES with have ≠ 3'b111 → LAUNCH with core_zero_mask = out_missing = ~have.
  - A frame with have = 3'b000 never times out.
- FUSION_SCHED_TIMEOUT_EN not defined:
  - No counter; COLLECT waits indefinitely.
  - core_zero_mask and out_missing are tied to 0.

## Test plan
- All three s_valid high at cycle 0 with out_ready=1 → core_launch at 1, res_wr_en at 5, out_valid at 6 with out_frame_id=0, out_missing=0.
- Staggered sensors (s0 at cycle 0, s2 at cycle 3, s1 at cycle 7) → each s_ready[i] drops after its own accept; single core_launch at 8.
- out_ready=0 with continuous input → exactly 4 launches, then credit_stall=1 and core_launch held off. Raising out_ready for one cycle → one pop and one further launch; ptr wrap verified over 10 frames.
- core_error=4'h3 in the result cycle of frame 2 only → out_error=3 for frame 2, 0 for frames 1 and 3.
- With FUSION_SCHED_TIMEOUT_EN: only s0 and s1 supplied → launch 64 cycles after the first accept with core_zero_mask=3'b100 and out_missing=3'b100. Without the macro, no launch ever occurs.
- rst asserted 2 cycles after a launch → no res_wr_en, out_valid=0; next frame carries out_frame_id=0.
